// File: rtl/seg_scan_counter.sv
// N-digit decimal up/down counter with clear/load and a time-multiplexed
// 7-segment driver (leading-zero blanking, per-digit dp, selectable polarity).

module seg_digit_lane (
  input  logic [3:0] bcd,
  input  logic       cin,
  input  logic       up,
  input  logic [3:0] ld_raw,
  output logic [3:0] nxt,
  output logic       cout,
  output logic [3:0] ld_val
);
  always_comb begin
    nxt  = bcd;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (bcd >= 4'd9) begin
          nxt  = 4'd0;
          cout = 1'b1;
        end else begin
          nxt = bcd + 4'd1;
        end
      end else begin
        if (bcd == 4'd0) begin
          nxt  = 4'd9;
          cout = 1'b1;
        end else begin
          nxt = bcd - 4'd1;
        end
      end
    end
  end

  // Non-decimal nibbles are stored as zero so the count stays valid BCD.
  assign ld_val = (ld_raw > 4'd9) ? 4'd0 : ld_raw;
endmodule

module seg_scan_counter #(
  parameter int DIGITS      = 4,
  parameter int TICK_DIV    = 50_000_000,
  parameter int SCAN_DIV    = 50_000,
  parameter int SEG_ACT_LOW = 1,
  parameter int COM_ACT_LOW = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cnt_en,
  input  logic                  cnt_up,
  input  logic                  cnt_clr,
  input  logic                  load_vld,
  input  logic [4*DIGITS-1:0]   load_bcd,
  input  logic                  lzb_en,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [4*DIGITS-1:0]   bcd_val,
  output logic                  wrap_pulse,
  output logic [DIGITS-1:0]     seg_com,
  output logic [7:0]            seg_out
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] COM_OFF = (COM_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  logic [DIGITS-1:0][3:0] bcd_q, bcd_nxt, ld_val, ld_raw;
  logic [DIGITS:0]        carry;
  logic [DIGITS:0]        zabove;
  logic [DIGITS-1:0]      blank_vec;
  logic [PW-1:0]          presc;
  logic                   tick;
  logic [SW-1:0]          scan_cnt;
  logic [IW-1:0]          scan_idx;

  assign ld_raw         = load_bcd;
  assign bcd_val        = bcd_q;
  assign carry[0]       = 1'b1;
  assign zabove[DIGITS] = 1'b1;

  // One lane per digit: carry/borrow ripples up, zero-run for blanking ripples down.
  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    seg_digit_lane u_lane (
      .bcd    (bcd_q[g]),
      .cin    (carry[g]),
      .up     (cnt_up),
      .ld_raw (ld_raw[g]),
      .nxt    (bcd_nxt[g]),
      .cout   (carry[g+1]),
      .ld_val (ld_val[g])
    );
    assign zabove[g]    = (bcd_q[g] == 4'd0) & zabove[g+1];
    assign blank_vec[g] = (g != 0) & lzb_en & zabove[g];
  end

  assign tick = cnt_en & (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bcd_q      <= '0;
      presc      <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (cnt_clr) begin
        bcd_q <= '0;
        presc <= '0;
      end else if (load_vld) begin
        bcd_q <= ld_val;
        presc <= '0;
      end else if (cnt_en) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          bcd_q      <= bcd_nxt;
          wrap_pulse <= carry[DIGITS];
        end
      end
    end
  end

  function automatic logic [6:0] font7(input logic [3:0] d);
    case (d)
      4'd0:    font7 = 7'h3F;
      4'd1:    font7 = 7'h06;
      4'd2:    font7 = 7'h5B;
      4'd3:    font7 = 7'h4F;
      4'd4:    font7 = 7'h66;
      4'd5:    font7 = 7'h6D;
      4'd6:    font7 = 7'h7D;
      4'd7:    font7 = 7'h07;
      4'd8:    font7 = 7'h7F;
      4'd9:    font7 = 7'h6F;
      default: font7 = 7'h00;
    endcase
  endfunction

  logic [3:0]        cur_digit;
  logic              cur_blank, cur_dp;
  logic [DIGITS-1:0] com_oh;
  logic [7:0]        seg_raw;

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    com_oh    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IW'(i)) begin
        cur_digit = bcd_q[i];
        cur_blank = blank_vec[i];
        cur_dp    = dp_mask[i];
        com_oh[i] = 1'b1;
      end
    end
    seg_raw = {cur_dp, cur_blank ? 7'h00 : font7(cur_digit)};
  end

  // Select and segments are registered together from the same index: no ghosting.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      seg_com  <= COM_OFF;
      seg_out  <= SEG_OFF;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      seg_com <= com_oh ^ COM_OFF;
      seg_out <= seg_raw ^ SEG_OFF;
    end
  end
endmodule
